// File: rtl/alu_issue_ctrl.sv
// Request/response front end for the registered lab1 ALU: decodes R-type funct codes,
// drives the ALU, waits out its latency and hands back the captured result with masked flags.
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [31:0]      req_src1,
    input  logic [31:0]      req_src2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             rsp_err,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [3:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic [CNT_W-1:0] op_count
);

    localparam int WCNT_W = $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic [31:0]         alu_src1_q, alu_src1_d;
    logic [31:0]         alu_src2_q, alu_src2_d;
    logic [3:0]          alu_control_q, alu_control_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                ovf_en_q, ovf_en_d;
    logic                cout_en_q, cout_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_result_q, rsp_result_d;
    logic                rsp_cout_q, rsp_cout_d;
    logic                rsp_overflow_q, rsp_overflow_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    op_count_q, op_count_d;

    logic                dec_legal;
    logic [3:0]          dec_ctrl;
    logic                dec_ovf_en;
    logic                dec_cout_en;

    // Flags only carry meaning for the arithmetic ops; the mask bits travel with the op.
    always_comb begin
        dec_legal   = 1'b1;
        dec_ctrl    = 4'b0000;
        dec_ovf_en  = 1'b0;
        dec_cout_en = 1'b0;
        case (req_funct)
            6'h20: begin dec_ctrl = 4'b0010; dec_ovf_en = 1'b1; dec_cout_en = 1'b1; end
            6'h22: begin dec_ctrl = 4'b0110; dec_ovf_en = 1'b1; dec_cout_en = 1'b1; end
            6'h24: dec_ctrl = 4'b0000;
            6'h25: dec_ctrl = 4'b0001;
            6'h27: dec_ctrl = 4'b1100;
            6'h2A: begin dec_ctrl = 4'b0111; dec_cout_en = 1'b1; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        alu_src1_d     = alu_src1_q;
        alu_src2_d     = alu_src2_q;
        alu_control_d  = alu_control_q;
        wait_cnt_d     = wait_cnt_q;
        ovf_en_d       = ovf_en_q;
        cout_en_d      = cout_en_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_cout_d     = rsp_cout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_err_d      = rsp_err_q;
        op_count_d     = op_count_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (dec_legal) begin
                        alu_src1_d    = req_src1;
                        alu_src2_d    = req_src2;
                        alu_control_d = dec_ctrl;
                        ovf_en_d      = dec_ovf_en;
                        cout_en_d     = dec_cout_en;
                        state_d       = ISSUE;
                    end else begin
                        // Unsupported funct never reaches the ALU; answer immediately.
                        rsp_valid_d    = 1'b1;
                        rsp_err_d      = 1'b1;
                        rsp_result_d   = '0;
                        rsp_cout_d     = 1'b0;
                        rsp_overflow_d = 1'b0;
                        state_d        = RESP;
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = WCNT_W'(ALU_LATENCY);
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WCNT_W'(1)) begin
                    rsp_valid_d    = 1'b1;
                    rsp_err_d      = 1'b0;
                    rsp_result_d   = alu_result;
                    rsp_cout_d     = alu_cout & cout_en_q;
                    rsp_overflow_d = alu_overflow & ovf_en_q;
                    state_d        = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b0;
            alu_src1_q     <= '0;
            alu_src2_q     <= '0;
            alu_control_q  <= 4'b0000;
            wait_cnt_q     <= '0;
            ovf_en_q       <= 1'b0;
            cout_en_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_cout_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            alu_src1_q     <= alu_src1_d;
            alu_src2_q     <= alu_src2_d;
            alu_control_q  <= alu_control_d;
            wait_cnt_q     <= wait_cnt_d;
            ovf_en_q       <= ovf_en_d;
            cout_en_q      <= cout_en_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_cout_q     <= rsp_cout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_err_q      <= rsp_err_d;
            op_count_q     <= op_count_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    // Zero flag is gated by valid so the idle/reset output stays 0.
    assign rsp_zero     = rsp_valid_q && (rsp_result_q == '0);
    assign rsp_cout     = rsp_cout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign alu_src1     = alu_src1_q;
    assign alu_src2     = alu_src2_q;
    assign alu_control  = alu_control_q;
    assign op_count     = op_count_q;

endmodule
